// File: rtl/dac_scheduler.sv
// DAC sample scheduler: a fixed-rate tick arbitrates two sample requesters
// (round-robin on contention) into a registered DAC code with underrun tracking.
module dac_scheduler #(
  parameter int unsigned DIV      = 100,
  parameter logic [7:0]  MIDSCALE = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] dac_data,
  output logic       sample_strobe,
  output logic       last_grant,
  output logic       underrun,
  output logic [7:0] underrun_cnt
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [15:0] RELOAD = 16'(DIV - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [7:0]  r_dac_data;
  logic        r_strobe;
  logic        r_last_grant;
  logic        r_underrun;
  logic [7:0]  r_underrun_cnt;
  logic        w_tick;
  logic        w_gnt0;
  logic        w_gnt1;

  // A tick whose cycle already sees enable low or rst high is suppressed, so
  // no transfer can slip through on the way out of RUN or into reset.
  assign w_tick = (r_state == S_RUN) && (r_cnt == 16'd0) && enable && !rst;

  assign w_gnt0 = w_tick && req0_valid && (!req1_valid || r_last_grant);
  assign w_gnt1 = w_tick && req1_valid && (!req0_valid || !r_last_grant);

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = RELOAD;
    case (r_state)
      S_IDLE: if (enable) w_state_nxt = S_RUN;
      S_RUN: begin
        if (!enable) w_state_nxt = S_IDLE;
        if (r_cnt != 16'd0) w_cnt_nxt = r_cnt - 16'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= RELOAD;
      r_dac_data     <= MIDSCALE;
      r_strobe       <= 1'b0;
      r_last_grant   <= 1'b1;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_strobe <= w_gnt0 | w_gnt1;
      if (w_gnt0) begin
        r_dac_data   <= req0_data;
        r_last_grant <= 1'b0;
      end else if (w_gnt1) begin
        r_dac_data   <= req1_data;
        r_last_grant <= 1'b1;
      end
      if (w_tick && !req0_valid && !req1_valid) begin
        r_underrun <= 1'b1;
        if (r_underrun_cnt != 8'hFF) r_underrun_cnt <= r_underrun_cnt + 8'd1;
      end
    end
  end

  assign req0_ready    = w_gnt0;
  assign req1_ready    = w_gnt1;
  assign dac_data      = r_dac_data;
  assign sample_strobe = r_strobe;
  assign last_grant    = r_last_grant;
  assign underrun      = r_underrun;
  assign underrun_cnt  = r_underrun_cnt;

endmodule

// File: tb/tb_dac_scheduler.sv
// Self-checking bench for dac_scheduler (DIV=4): directed scenarios plus a
// randomized run, all checked against a cycle-level behavioural model.
module tb_dac_scheduler;

  localparam int unsigned DIV      = 4;
  localparam logic [7:0]  MIDSCALE = 8'h80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_valid = 1'b0;
  logic       req0_ready;
  logic [7:0] req1_data = 8'h00;
  logic       req1_valid = 1'b0;
  logic       req1_ready;
  logic [7:0] dac_data;
  logic       sample_strobe;
  logic       last_grant;
  logic       underrun;
  logic [7:0] underrun_cnt;

  int total = 0;
  int bad   = 0;

  // Model: m_run is whether the current cycle is in RUN, m_k is how many RUN
  // cycles precede it in the current enabled stretch.
  bit       m_run;
  int       m_k;
  bit       m_tick;
  bit [7:0] m_dac;
  bit       m_strobe;
  bit       m_last;
  bit       m_und;
  int       m_cnt;
  bit       e_r0, e_r1, a_r0, a_r1;

  dac_scheduler #(.DIV(DIV), .MIDSCALE(MIDSCALE)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .dac_data(dac_data), .sample_strobe(sample_strobe), .last_grant(last_grant),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, capture the combinational readies, advance the
  // model across the rising edge, and return just after that edge.
  task automatic step(input logic en, input logic rs, input logic v0,
                      input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    @(negedge clk);
    enable = en; rst = rs;
    req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
    #1;
    m_tick = !rs && en && m_run && ((m_k % DIV) == DIV - 1);
    e_r0 = m_tick && v0 && (!v1 || m_last);
    e_r1 = m_tick && v1 && (!v0 || !m_last);
    a_r0 = req0_ready;
    a_r1 = req1_ready;
    @(posedge clk);
    if (rs) begin
      m_run = 0; m_k = 0; m_dac = MIDSCALE; m_strobe = 0;
      m_last = 1; m_und = 0; m_cnt = 0;
    end else begin
      m_strobe = e_r0 | e_r1;
      if (e_r0) begin m_dac = d0; m_last = 0; end
      else if (e_r1) begin m_dac = d1; m_last = 1; end
      if (m_tick && !v0 && !v1) begin
        m_und = 1;
        if (m_cnt < 255) m_cnt++;
      end
      m_k   = (m_run && en) ? m_k + 1 : 0;
      m_run = en;
    end
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dac_data !== MIDSCALE || last_grant !== 1'b1 || underrun !== 1'b0 ||
        underrun_cnt !== 8'h00 || sample_strobe !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: dac=%h lg=%b und=%b cnt=%h stb=%b, want dac=80 lg=1 und=0 cnt=00 stb=0",
               dac_data, last_grant, underrun, underrun_cnt, sample_strobe);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 8'hA5);
      total++;
      if (dac_data !== 8'h80 || sample_strobe !== 1'b0 || a_r0 || a_r1) begin
        bad++;
        $display("FAIL idle_hold cyc %0d: dac=%h stb=%b r0=%b r1=%b, want 80/0/0/0",
                 i, dac_data, sample_strobe, a_r0, a_r1);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    step(1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 8'h00);
      total++;
      if (a_r0 !== ((i % 4) == 3) || a_r1 !== 1'b0 || a_r0 !== e_r0) begin
        bad++;
        $display("FAIL single_ready cyc %0d: r0=%b r1=%b, want r0=%b r1=0", i, a_r0, a_r1, (i % 4) == 3);
      end
      total++;
      if (sample_strobe !== ((i % 4) == 3) || underrun !== 1'b0 ||
          dac_data !== (i >= 3 ? 8'h10 : 8'h80)) begin
        bad++;
        $display("FAIL single_out cyc %0d: stb=%b und=%b dac=%h", i, sample_strobe, underrun, dac_data);
      end
    end
  endtask

  task automatic test_round_robin();
    int g;
    logic [7:0] exp_d;
    g = 0;
    do_reset();
    step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, 8'h55);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, 8'h55);
      if (a_r0 || a_r1) begin
        exp_d = (g % 2 == 0) ? 8'hAA : 8'h55;
        total++;
        if (a_r0 !== (g % 2 == 0) || a_r1 !== (g % 2 == 1) || dac_data !== exp_d ||
            last_grant !== logic'(g % 2) || sample_strobe !== 1'b1) begin
          bad++;
          $display("FAIL rr_grant %0d: r0=%b r1=%b dac=%h lg=%b, want dac=%h lg=%0d",
                   g, a_r0, a_r1, dac_data, last_grant, exp_d, g % 2);
        end
        g++;
      end
    end
    total++;
    if (g != 5) begin
      bad++;
      $display("FAIL rr_count: grants=%0d, want 5", g);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    step(1'b1, 1'b0, 1'b1, 8'h42, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'h42, 1'b0, 8'h00);
    for (int i = 0; i < 300 * DIV; i++) step(1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 8'h22);
    total++;
    if (underrun !== 1'b1 || underrun_cnt !== 8'hFF || dac_data !== 8'h42 ||
        underrun_cnt !== 8'(m_cnt)) begin
      bad++;
      $display("FAIL underrun_sat: und=%b cnt=%h dac=%h, want und=1 cnt=ff dac=42",
               underrun, underrun_cnt, dac_data);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    total++;
    if (underrun !== 1'b1 || underrun_cnt !== 8'hFF) begin
      bad++;
      $display("FAIL underrun_sticky: und=%b cnt=%h, want 1/ff", underrun, underrun_cnt);
    end
  endtask

  task automatic test_enable_drop();
    int budget;
    budget = 0;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    while (!(m_run && (m_k % DIV) == 2) && budget < 50) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      budget++;
    end
    total++;
    if (budget >= 50) begin
      bad++;
      $display("FAIL drop_align: period cycle 2 not reached in %0d cycles", budget);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00);
      total++;
      if (a_r0 || sample_strobe !== 1'b0 || dac_data !== 8'h80) begin
        bad++;
        $display("FAIL drop_low cyc %0d: r0=%b stb=%b dac=%h, want 0/0/80", i, a_r0, sample_strobe, dac_data);
      end
    end
    step(1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00);
    for (int j = 1; j <= 4; j++) begin
      step(1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00);
      total++;
      if (a_r0 !== (j == 4) || a_r0 !== e_r0) begin
        bad++;
        $display("FAIL drop_reenable +%0d: r0=%b, want %b", j, a_r0, j == 4);
      end
    end
    total++;
    if (dac_data !== 8'h3C || sample_strobe !== 1'b1) begin
      bad++;
      $display("FAIL drop_transfer: dac=%h stb=%b, want 3c/1", dac_data, sample_strobe);
    end
  endtask

  task automatic test_reset_in_tick();
    int budget;
    budget = 0;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    while (!(m_run && (m_k % DIV) == DIV - 1) && budget < 50) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      budget++;
    end
    step(1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 8'h00);
    total++;
    if (budget >= 50 || a_r0 !== 1'b0 || dac_data !== 8'h80 || underrun_cnt !== 8'h00 ||
        underrun !== 1'b0 || sample_strobe !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_tick: r0=%b dac=%h cnt=%h und=%b stb=%b, want 0/80/00/0/0",
               a_r0, dac_data, underrun_cnt, underrun, sample_strobe);
    end
  endtask

  task automatic test_random();
    logic en, rs, v0, v1;
    logic [7:0] d0, d1;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      rs = ($urandom_range(0, 199) == 0);
      v0 = $urandom_range(0, 2) != 0;
      v1 = $urandom_range(0, 1) != 0;
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      step(en, rs, v0, d0, v1, d1);
      total++;
      if (a_r0 !== e_r0 || a_r1 !== e_r1) begin
        bad++;
        $display("FAIL rand_ready cyc %0d: r0=%b r1=%b, want %b %b", i, a_r0, a_r1, e_r0, e_r1);
      end
      total++;
      if (dac_data !== m_dac || sample_strobe !== m_strobe || last_grant !== m_last ||
          underrun !== m_und || underrun_cnt !== 8'(m_cnt)) begin
        bad++;
        $display("FAIL rand_state cyc %0d: dac=%h stb=%b lg=%b und=%b cnt=%h, want %h %b %b %b %h",
                 i, dac_data, sample_strobe, last_grant, underrun, underrun_cnt,
                 m_dac, m_strobe, m_last, m_und, 8'(m_cnt));
      end
    end
  endtask

  initial begin
    m_run = 0; m_k = 0; m_dac = MIDSCALE; m_strobe = 0;
    m_last = 1; m_und = 0; m_cnt = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_underrun();
    test_enable_drop();
    test_reset_in_tick();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
